// File: rtl/even_scan_pkg.sv
// Shared types and constants for the even-byte window scanner.
package even_scan_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int CNT_W     = 9;
    localparam int NUM_PORTS = 8;

    typedef enum logic [1:0] {IDLE, SCAN, FINISH} scan_state_t;

    // Zero is a sentinel, so only non-zero even bytes count.
    function automatic logic is_pare(input logic [DATA_W-1:0] data);
        return (data != '0) && !data[0];
    endfunction

endpackage

// File: rtl/lane_pare_counter.sv
// Combinational popcount of valid lanes whose read data is a pare.
module lane_pare_counter #(
    parameter int NUM_PORTS = 8,
    parameter int DATA_W    = 8,
    parameter int HIT_W     = $clog2(NUM_PORTS + 1)
) (
    input  logic [NUM_PORTS-1:0]        valid,
    input  logic [NUM_PORTS*DATA_W-1:0] data_bus,
    output logic [HIT_W-1:0]            hits
);
    import even_scan_pkg::*;

    always_comb begin
        hits = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (valid[i] && is_pare(data_bus[i*DATA_W +: DATA_W]))
                hits = hits + HIT_W'(1);
        end
    end

endmodule

// File: rtl/even_scan_scheduler.sv
// Walks an address window NUM_PORTS addresses per clock and counts pares
// returned by a combinational-read multi-port array.
module even_scan_scheduler #(
    parameter int NUM_PORTS = 8,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 9
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           first_addr,
    input  logic [ADDR_W-1:0]           last_addr,
    output logic [NUM_PORTS*ADDR_W-1:0] addr_bus,
    input  logic [NUM_PORTS*DATA_W-1:0] data_bus,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [CNT_W-1:0]            count
);
    import even_scan_pkg::*;

    localparam int PTR_W = ADDR_W + 1;
    localparam int HIT_W = $clog2(NUM_PORTS + 1);

    scan_state_t                 state_q, state_d;
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic [ADDR_W-1:0]           last_q, last_d;
    logic                        err_q, err_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [NUM_PORTS*ADDR_W-1:0] addr_q, addr_d;

    logic [NUM_PORTS-1:0] valid;
    logic [HIT_W-1:0]     hits;
    logic                 load_en;
    logic [PTR_W-1:0]     load_base;
    logic [ADDR_W-1:0]    load_lim;
    logic [PTR_W-1:0]     lane_a;

    // Extra pointer bit keeps lanes past the top of memory from wrapping into the window.
    always_comb begin
        valid = '0;
        if (state_q == SCAN) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++)
                valid[i] = (ptr_q + PTR_W'(i)) <= {1'b0, last_q};
        end
    end

    lane_pare_counter #(
        .NUM_PORTS(NUM_PORTS),
        .DATA_W   (DATA_W),
        .HIT_W    (HIT_W)
    ) u_lane_pare_counter (
        .valid   (valid),
        .data_bus(data_bus),
        .hits    (hits)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        last_d    = last_q;
        err_d     = err_q;
        count_d   = count_q;
        addr_d    = addr_q;
        load_en   = 1'b0;
        load_base = '0;
        load_lim  = '0;
        lane_a    = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = '0;
                    if (first_addr <= last_addr) begin
                        last_d    = last_addr;
                        ptr_d     = {1'b0, first_addr};
                        load_en   = 1'b1;
                        load_base = {1'b0, first_addr};
                        load_lim  = last_addr;
                        state_d   = SCAN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end
                end
            end
            SCAN: begin
                count_d = count_q + CNT_W'(hits);
                if ((ptr_q + PTR_W'(NUM_PORTS)) > {1'b0, last_q}) begin
                    addr_d  = '0;
                    state_d = FINISH;
                end else begin
                    ptr_d     = ptr_q + PTR_W'(NUM_PORTS);
                    load_en   = 1'b1;
                    load_base = ptr_q + PTR_W'(NUM_PORTS);
                    load_lim  = last_q;
                end
            end
            FINISH: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (load_en) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                lane_a = load_base + PTR_W'(i);
                addr_d[i*ADDR_W +: ADDR_W] =
                    (lane_a <= {1'b0, load_lim}) ? lane_a[ADDR_W-1:0] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            last_q  <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            err_q   <= err_d;
            count_q <= count_d;
            addr_q  <= addr_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FINISH);
    assign error    = done && err_q;
    assign count    = count_q;
    assign addr_bus = addr_q;

endmodule

// File: tb/tb_even_scan_scheduler.sv
// Scoreboard bench for even_scan_scheduler against a behavioural 256x8 array.
module tb_even_scan_scheduler;

    localparam int NP = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  first_addr = '0;
    logic [7:0]  last_addr = '0;
    logic [63:0] addr_bus;
    logic [63:0] data_bus;
    logic        busy, done, error;
    logic [8:0]  count;

    logic [7:0]  mem [256];

    typedef struct {
        logic [8:0] cnt;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   win_f = 0;
    int   win_l = 255;
    int   prev_count = 0;

    always #5 clk = ~clk;

    even_scan_scheduler #(
        .NUM_PORTS(8),
        .ADDR_W   (8),
        .DATA_W   (8),
        .CNT_W    (9)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .first_addr(first_addr),
        .last_addr (last_addr),
        .addr_bus  (addr_bus),
        .data_bus  (data_bus),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .count     (count)
    );

    always_comb begin
        data_bus = '0;
        for (int i = 0; i < NP; i++)
            data_bus[i*8 +: 8] = mem[addr_bus[i*8 +: 8]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation on every done pulse; checks issued addresses stay in window.
    initial begin
        int   busy_cyc;
        int   a;
        exp_t e;
        busy_cyc = 0;
        forever begin
            @(negedge clk);
            if (reset && busy) begin
                busy_cyc++;
                if (!done) begin
                    for (int i = 0; i < NP; i++) begin
                        a = int'(addr_bus[i*8 +: 8]);
                        if (a != 0)
                            check("addr_in_window", (a >= win_f && a <= win_l), 1);
                    end
                end else if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = sb.pop_front();
                    check("count", count, e.cnt);
                    check("error", error, e.err);
                    check("busy_cycles", busy_cyc, e.cyc);
                end
            end else begin
                busy_cyc = 0;
            end
        end
    end

    task automatic run(input int f, input int l, input logic [8:0] ecnt, input logic eerr,
                       input int ecyc, input bit mid, input logic [63:0] tail);
        int n;
        bit seen;
        exp_t e;
        @(negedge clk);
        check("count_held", count, prev_count);
        first_addr = 8'(f);
        last_addr  = 8'(l);
        win_f      = f;
        win_l      = l;
        start      = 1'b1;
        e.cnt = ecnt;
        e.err = eerr;
        e.cyc = ecyc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        seen = 0;
        while (!seen && n < 100) begin
            if (n == 2 && tail != 0) check("tail_lanes", addr_bus, tail);
            if (mid && n == 10) begin
                start = 1'b1;
                first_addr = 8'd5;
                last_addr = 8'd5;
            end
            if (mid && n == 11) start = 1'b0;
            if (done) seen = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL timeout actual=%0d required=%0d", n, ecyc);
        end
        prev_count = int'(ecnt);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'd2;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_count", count, 0);
        check("rst_addr", addr_bus, 0);
        reset = 1'b1;

        run(0, 255, 9'd256, 1'b0, 33, 0, 64'h0);

        for (int a = 0; a < 256; a++) mem[a] = 8'(a);
        run(0, 255, 9'd127, 1'b0, 33, 0, 64'h0);
        run(10, 20, 9'd6, 1'b0, 3, 0, 64'h0000_0000_0014_1312);

        mem[5] = 8'd4;
        run(5, 5, 9'd1, 1'b0, 2, 0, 64'h0);
        run(200, 100, 9'd0, 1'b1, 1, 0, 64'h0);

        for (int a = 0; a < 256; a++) mem[a] = 8'd0;
        run(248, 255, 9'd0, 1'b0, 2, 0, 64'h0);

        for (int a = 0; a < 256; a++) mem[a] = 8'd2;
        run(0, 255, 9'd256, 1'b0, 33, 1, 64'h0);

        mem[0] = 8'd0; mem[1] = 8'd1; mem[2] = 8'd2; mem[3] = 8'd3;
        mem[4] = 8'd4; mem[5] = 8'd5; mem[6] = 8'd6; mem[7] = 8'd8;
        run(0, 7, 9'd4, 1'b0, 2, 0, 64'h0);

        // Abort a scan with reset; no expectation is queued, so any done is flagged.
        @(negedge clk);
        win_f = 0;
        win_l = 255;
        first_addr = 8'd0;
        last_addr = 8'd255;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_abort_busy", busy, 1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_count", count, 0);
        check("abort_addr", addr_bus, 0);
        check("abort_done", done, 0);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("post_abort_count", count, 0);

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
